// File: rtl/xip_read_cache_if.sv
// Bus bundle for the XIP read cache: the CPU read port on one side and
// the serial-flash word reader on the other. The cache is the slave;
// the surrounding system (CPU plus flash reader) is the master.
interface xip_read_cache_if;
  logic        mem_rstrb;
  logic [21:0] mem_word_address;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;
  logic        invalidate;
  logic        flash_rstrb;
  logic [21:0] flash_word_address;
  logic [31:0] flash_rdata;
  logic        flash_rbusy;

  modport slave (
    input  mem_rstrb, mem_word_address, invalidate, flash_rdata, flash_rbusy,
    output mem_rdata, mem_rbusy, flash_rstrb, flash_word_address
  );

  modport master (
    output mem_rstrb, mem_word_address, invalidate, flash_rdata, flash_rbusy,
    input  mem_rdata, mem_rbusy, flash_rstrb, flash_word_address
  );
endinterface

// File: rtl/xip_read_cache.sv
// Direct-mapped, one-word-per-line read cache in front of the serial-flash
// XIP reader. Hits answer one cycle after the strobe; misses fetch a single
// word from flash, fill the line and return that word.
module xip_read_cache #(
  parameter int INDEX_BITS = 6
) (
  input logic            clk,
  input logic            reset,
  xip_read_cache_if.slave bus
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 22 - INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_WAIT
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Line storage: valid bits and tags in flops, data in block RAM.
  logic [LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag [LINES];
  logic [31:0]         r_ram [LINES];
  logic [31:0]         r_ram_q;

  // Request and return path.
  logic [21:0] r_req_addr;
  logic [31:0] r_ret;
  logic        r_sel_ret;     // 1: mem_rdata comes from the return register
  logic        r_first_wait;  // first WAIT cycle, flash_rbusy not yet valid
  logic        r_inval_pend;  // an invalidate hit the current miss

  logic [INDEX_BITS-1:0] w_req_idx;
  logic [TAG_BITS-1:0]   w_req_tag;
  logic [INDEX_BITS-1:0] w_strb_idx;
  logic                  w_hit;
  logic                  w_accept;
  logic                  w_fill;
  logic                  w_busy;
  logic                  w_flash_rstrb;

  assign w_req_idx  = r_req_addr[INDEX_BITS-1:0];
  assign w_req_tag  = r_req_addr[21:INDEX_BITS];
  assign w_strb_idx = bus.mem_word_address[INDEX_BITS-1:0];
  assign w_hit      = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus handshake decode. Strobes while busy are dropped.
  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    w_fill        = 1'b0;
    w_busy        = 1'b0;
    w_flash_rstrb = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.mem_rstrb) begin
          w_accept     = 1'b1;
          w_state_next = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (w_hit) begin
          // A hit frees the port immediately, so a new strobe is taken now.
          if (bus.mem_rstrb) begin
            w_accept     = 1'b1;
            w_state_next = S_LOOKUP;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_flash_rstrb = 1'b1;
          w_busy        = 1'b1;
          w_state_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        w_busy = 1'b1;
        if (!r_first_wait && !bus.flash_rbusy) begin
          w_fill       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request capture, return register and miss bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_addr   <= '0;
      r_ret        <= '0;
      r_sel_ret    <= 1'b1;
      r_first_wait <= 1'b0;
      r_inval_pend <= 1'b0;
    end else begin
      r_first_wait <= (r_state == S_LOOKUP) && !w_hit;
      if (w_accept) begin
        r_req_addr   <= bus.mem_word_address;
        r_sel_ret    <= 1'b0;
        r_inval_pend <= 1'b0;
      end
      if (bus.invalidate && w_busy) begin
        r_inval_pend <= 1'b1;
      end
      if (w_fill) begin
        r_ret     <= bus.flash_rdata;
        r_sel_ret <= 1'b1;
      end
    end
  end

  // Per-line valid bits: flash invalidate wins over a coincident fill.
  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (reset || bus.invalidate) begin
          r_valid[gi] <= 1'b0;
        end else if (w_fill && !r_inval_pend && (w_req_idx == INDEX_BITS'(gi))) begin
          r_valid[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Tag/data write on fill and registered data read on an accepted strobe.
  // The write is gated by reset so an abandoned fill never lands.
  always_ff @(posedge clk) begin
    if (w_fill && !reset) begin
      r_ram[w_req_idx] <= bus.flash_rdata;
      r_tag[w_req_idx] <= w_req_tag;
    end
    if (w_accept) begin
      r_ram_q <= r_ram[w_strb_idx];
    end
  end

  assign bus.mem_rdata          = r_sel_ret ? r_ret : r_ram_q;
  assign bus.mem_rbusy          = w_busy;
  assign bus.flash_rstrb        = w_flash_rstrb;
  assign bus.flash_word_address = r_req_addr;

endmodule
